rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_SIZE, default 8, entry count; entry id ("rob id") width is 3 bits.
REQ-002 clk_in  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 is_dc  input  1  decoder issues one instruction this cycle.
REQ-006 dc_type  input  2  0=reg-write (incl. jal/jalr/lui/auipc/load), 1=branch, 2=store, 3=reserved (treated as 0).
REQ-007 dc_rd  input  5  destination register.
REQ-008 dc_pred_taken  input  1  fetch prediction for branch.
REQ-009 dc_alt_pc  input  32  PC to redirect to if branch prediction wrong.
REQ-010 rob_full  output  1  registered; decoder issues nothing while high.
REQ-011 rob_tail_id  output  3  id the next issued instruction receives (Qdest).
REQ-012 rs_has_output, rs_rob_id[3], rs_output[32]  input  ALU result; for branch, rs_output[0]=taken.
REQ-013 is_lsb, lsb_rob_id[3], lsb_res[32]  input  load data, or store-resolved notice.
REQ-014 q1_id, q2_id  input  3  operand lookup ids from decoder.
REQ-015 q1_ready, q2_ready  output  1; q1_value, q2_value  output  32  combinational lookup results.
REQ-016 commit_valid  output  1; commit_rd  output  5; commit_value  output  32; commit_id  output  3  register-file write pulse.
REQ-017 commit_store  output  1; commit_store_id  output  3  store-release pulse to LSB.
REQ-018 rob_clear  output  1; clear_pc  output  32  flush pulse and redirect target.

Function
REQ-019 Circular buffer: head, tail (3-bit, wrap 7->0), count (4-bit, 0..8); per entry busy, ready, type, rd, pred_taken, alt_pc, value.
REQ-020 Issue: when is_dc && !rob_clear, entry[tail] written busy=1 ready=0, tail advances by 1; rob_tail_id = tail.
REQ-021 Result: rs_has_output sets ready=1, value=rs_output at rs_rob_id; is_lsb likewise at lsb_rob_id; both applied when ids differ; results to non-busy entries ignored.
REQ-022 rob_full <= (next_count >= ROB_SIZE-1), one-entry slack covering its one-cycle latency.
REQ-023 Commit: at most one per cycle, when entry[head] busy && ready; head advances, entry freed, count decrements.
REQ-024 Reg-write commit: next cycle commit_valid=1 with rd/value/id for exactly one cycle; commit_valid stays 0 when rd=0 (entry still retires).
REQ-025 Store commit: next cycle commit_store=1, commit_store_id=head for one cycle.
REQ-026 Branch commit, value[0]==pred_taken: retire only, no pulse.
REQ-027 Branch commit, value[0]!=pred_taken: next cycle rob_clear=1, clear_pc=alt_pc for one cycle; all busy cleared; head=tail=count=0; rob_full=0.
REQ-028 Cycle with rob_clear high: is_dc and all results ignored; issue resumes the following cycle with id 0.
REQ-029 Same-cycle issue and commit: count unchanged; issue into slot being freed impossible (full slack guarantees).
REQ-030 Lookup: q_ready=1, q_value=entry value if entry ready; else if rs_has_output && rs_rob_id==q_id then rs_output bypassed; else if is_lsb && lsb_rob_id==q_id then lsb_res; else q_ready=0, q_value=0.
REQ-031 Result for the head entry in cycle T: commit occurs earliest in cycle T+1 (no same-cycle result-to-commit).
REQ-032 rdy_in low: no issue, result capture, or commit; pulse outputs held 0.

Reset
REQ-033 rst_in high (async): head=tail=count=0, all busy=0, rob_full=0, rob_tail_id=0, commit_valid=0, commit_store=0, rob_clear=0, clear_pc=0, commit_rd=0, commit_value=0, commit_id=0, commit_store_id=0.
REQ-034 Reset mid-operation discards all in-flight entries; no pulse emitted after deassertion until a new commit.

Verification
REQ-035 Issue reg-write rd=5 (id0), rs result id0 value 0x1234 -> two cycles later commit_valid=1 rd=5 value 0x1234 id=0 for one cycle.
REQ-036 Issue ids0..6 without results -> rob_full=1 after 7th issue; commit id0 -> rob_full falls next cycle; tail wraps 7->0 correctly.
REQ-037 Issue branch pred_taken=1 alt_pc=0x100 then two reg-writes; result id0 value 0 -> rob_clear=1 clear_pc=0x100 one cycle; count=0; later issue gets id 0.
REQ-038 Results out of order (id1 before id0) -> commits strictly in order id0 then id1.
REQ-039 Lookup q1_id=2 in cycle rs_rob_id=2 result 0xAA arrives -> q1_ready=1 q1_value=0xAA same cycle; id not yet done -> q1_ready=0.
REQ-040 Store id0, is_lsb id0 -> commit_store=1 commit_store_id=0; rst_in pulse mid-sequence -> all outputs zero immediately.

Source files
------------

// File: rtl/rob.sv
// rob: in-order reorder buffer with result capture, operand lookup, commit and branch flush
module rob #(
  parameter int ROB_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        is_dc,
  input  logic [1:0]  dc_type,
  input  logic [4:0]  dc_rd,
  input  logic        dc_pred_taken,
  input  logic [31:0] dc_alt_pc,
  output logic        rob_full,
  output logic [2:0]  rob_tail_id,
  input  logic        rs_has_output,
  input  logic [2:0]  rs_rob_id,
  input  logic [31:0] rs_output,
  input  logic        is_lsb,
  input  logic [2:0]  lsb_rob_id,
  input  logic [31:0] lsb_res,
  input  logic [2:0]  q1_id,
  input  logic [2:0]  q2_id,
  output logic        q1_ready,
  output logic        q2_ready,
  output logic [31:0] q1_value,
  output logic [31:0] q2_value,
  output logic        commit_valid,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic [2:0]  commit_id,
  output logic        commit_store,
  output logic [2:0]  commit_store_id,
  output logic        rob_clear,
  output logic [31:0] clear_pc
);
  localparam logic [3:0] FULL_AT = 4'(ROB_SIZE - 1);
  logic [2:0] head, tail;
  logic [3:0] count, next_count;
  logic [7:0] busy, ready;
  logic [1:0]  typ  [ROB_SIZE];
  logic [4:0]  rd   [ROB_SIZE];
  logic        pred [ROB_SIZE];
  logic [31:0] alt  [ROB_SIZE];
  logic [31:0] val  [ROB_SIZE];
  logic issue, rs_ok, lsb_ok, do_commit, is_br, is_st, is_rw, mispredict;
  logic q1_hit, q2_hit;
  assign rob_tail_id = tail;
  // decode this cycle's issue, result capture and commit decisions
  always_comb begin
    issue      = rdy_in && is_dc && !rob_clear;
    rs_ok      = rdy_in && !rob_clear && rs_has_output && busy[rs_rob_id];
    lsb_ok     = rdy_in && !rob_clear && is_lsb && busy[lsb_rob_id];
    do_commit  = rdy_in && busy[head] && ready[head];
    is_br      = typ[head] == 2'd1;
    is_st      = typ[head] == 2'd2;
    is_rw      = !is_br && !is_st;
    mispredict = do_commit && is_br && (val[head][0] != pred[head]);
    next_count = count + 4'(issue) - 4'(do_commit);
  end
  // operand lookup: stored result first, then same-cycle ALU, then LSB bypass
  always_comb begin
    q1_hit   = busy[q1_id] && ready[q1_id];
    q2_hit   = busy[q2_id] && ready[q2_id];
    q1_ready = q1_hit || (rs_has_output && rs_rob_id == q1_id) || (is_lsb && lsb_rob_id == q1_id);
    q2_ready = q2_hit || (rs_has_output && rs_rob_id == q2_id) || (is_lsb && lsb_rob_id == q2_id);
    q1_value = q1_hit ? val[q1_id] : (rs_has_output && rs_rob_id == q1_id) ? rs_output :
               (is_lsb && lsb_rob_id == q1_id) ? lsb_res : 32'd0;
    q2_value = q2_hit ? val[q2_id] : (rs_has_output && rs_rob_id == q2_id) ? rs_output :
               (is_lsb && lsb_rob_id == q2_id) ? lsb_res : 32'd0;
  end
  // control state and registered pulse outputs; a mispredict flushes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      rob_full        <= 1'b0;
      commit_valid    <= 1'b0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_id       <= '0;
      commit_store    <= 1'b0;
      commit_store_id <= '0;
      rob_clear       <= 1'b0;
      clear_pc        <= '0;
    end else if (!rdy_in) begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      rob_clear    <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      rob_clear    <= 1'b0;
      if (mispredict) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        busy      <= '0;
        rob_full  <= 1'b0;
        rob_clear <= 1'b1;
        clear_pc  <= alt[head];
      end else begin
        if (issue) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 3'd1;
        end
        if (rs_ok) ready[rs_rob_id] <= 1'b1;
        if (lsb_ok) ready[lsb_rob_id] <= 1'b1;
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + 3'd1;
          if (is_rw && rd[head] != 5'd0) begin
            commit_valid <= 1'b1;
            commit_rd    <= rd[head];
            commit_value <= val[head];
            commit_id    <= head;
          end
          if (is_st) begin
            commit_store    <= 1'b1;
            commit_store_id <= head;
          end
        end
        count    <= next_count;
        rob_full <= next_count >= FULL_AT;
      end
    end
  end
  // entry payload; validity is tracked by busy/ready so no reset is needed here
  always_ff @(posedge clk_in) begin
    if (issue) begin
      typ[tail]  <= dc_type;
      rd[tail]   <= dc_rd;
      pred[tail] <= dc_pred_taken;
      alt[tail]  <= dc_alt_pc;
    end
    if (rs_ok) val[rs_rob_id] <= rs_output;
    if (lsb_ok) val[lsb_rob_id] <= lsb_res;
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: randomized bench checking rob against a queue-based reference model
module tb_rob;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0, is_dc = 1'b0;
  logic [1:0]  dc_type = '0;
  logic [4:0]  dc_rd = '0;
  logic        dc_pred_taken = 1'b0;
  logic [31:0] dc_alt_pc = '0;
  logic        rob_full;
  logic [2:0]  rob_tail_id;
  logic        rs_has_output = 1'b0, is_lsb = 1'b0;
  logic [2:0]  rs_rob_id = '0, lsb_rob_id = '0, q1_id = '0, q2_id = '0;
  logic [31:0] rs_output = '0, lsb_res = '0;
  logic        q1_ready, q2_ready, commit_valid, commit_store, rob_clear;
  logic [31:0] q1_value, q2_value, commit_value, clear_pc;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_id, commit_store_id;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .is_dc(is_dc), .dc_type(dc_type),
    .dc_rd(dc_rd), .dc_pred_taken(dc_pred_taken), .dc_alt_pc(dc_alt_pc), .rob_full(rob_full),
    .rob_tail_id(rob_tail_id), .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id),
    .rs_output(rs_output), .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_id(commit_id),
    .commit_store(commit_store), .commit_store_id(commit_store_id),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  id;
    logic [1:0]  t;
    logic [4:0]  rd;
    logic        p;
    logic [31:0] alt;
    logic        rdy;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  m_tail;
  logic        m_full, m_clr, e_cv, e_cs;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_pc;
  logic [2:0]  e_id, e_sid;
  int checks = 0, failures = 0, n_commit = 0, n_clear = 0, n_store = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = '0; m_full = 0; m_clr = 0; e_cv = 0; e_cs = 0;
  endtask

  task automatic lookup(input logic [2:0] id, output logic r, output logic [31:0] v);
    r = 0; v = '0;
    foreach (mq[i]) if (mq[i].id == id && mq[i].rdy) begin r = 1; v = mq[i].v; end
    if (!r && rs_has_output && rs_rob_id == id) begin r = 1; v = rs_output; end
    else if (!r && is_lsb && lsb_rob_id == id) begin r = 1; v = lsb_res; end
  endtask

  task automatic apply_result(input logic [2:0] id, input logic [31:0] v);
    foreach (mq[i]) if (mq[i].id == id) begin mq[i].rdy = 1; mq[i].v = v; end
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    ent_t h;
    logic was_clr;
    was_clr = m_clr;
    e_cv = 0; e_cs = 0; m_clr = 0;
    if (!rdy_in) return;
    if (mq.size() > 0 && mq[0].rdy) begin
      h = mq.pop_front();
      n_commit++;
      if (h.t == 2'd1 && h.v[0] != h.p) begin
        mq.delete(); m_tail = '0; m_full = 0; m_clr = 1; e_pc = h.alt; n_clear++;
        return;
      end
      if (h.t == 2'd2) begin e_cs = 1; e_sid = h.id; n_store++; end
      else if (h.t != 2'd1 && h.rd != 0) begin e_cv = 1; e_rd = h.rd; e_val = h.v; e_id = h.id; end
    end
    if (!was_clr) begin
      if (rs_has_output) apply_result(rs_rob_id, rs_output);
      if (is_lsb) apply_result(lsb_rob_id, lsb_res);
      if (is_dc) begin
        mq.push_back('{id: m_tail, t: dc_type, rd: dc_rd, p: dc_pred_taken, alt: dc_alt_pc, rdy: 0, v: '0});
        m_tail = m_tail + 3'd1;
      end
    end
    m_full = mq.size() >= 7;
  endtask

  function automatic logic [2:0] pick_id();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) return mq[$urandom_range(0, mq.size() - 1)].id;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_full"}, 32'(rob_full), 0);
    chk({tag, "_tail"}, 32'(rob_tail_id), 0);
    chk({tag, "_cv"}, 32'(commit_valid), 0);
    chk({tag, "_cs"}, 32'(commit_store), 0);
    chk({tag, "_clr"}, 32'(rob_clear), 0);
    chk({tag, "_pc"}, clear_pc, 0);
    chk({tag, "_rd"}, 32'(commit_rd), 0);
    chk({tag, "_val"}, commit_value, 0);
    chk({tag, "_id"}, 32'(commit_id), 0);
    chk({tag, "_sid"}, 32'(commit_store_id), 0);
  endtask

  initial begin
    logic er;
    logic [31:0] ev;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_zero_outputs("reset");
    rst_in = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rdy_in        = $urandom_range(0, 9) != 0;
      is_dc         = !m_full && $urandom_range(0, 2) != 0;
      dc_type       = 2'($urandom_range(0, 3));
      dc_rd         = $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      dc_pred_taken = 1'($urandom_range(0, 1));
      dc_alt_pc     = $urandom;
      rs_has_output = $urandom_range(0, 1);
      rs_rob_id     = pick_id();
      rs_output     = $urandom;
      is_lsb        = $urandom_range(0, 2) == 0;
      lsb_rob_id    = pick_id();
      lsb_res       = $urandom;
      if (rs_has_output && lsb_rob_id == rs_rob_id) is_lsb = 0;
      q1_id         = pick_id();
      q2_id         = pick_id();
      #1;
      lookup(q1_id, er, ev);
      chk("q1_ready", 32'(q1_ready), 32'(er));
      chk("q1_value", q1_value, ev);
      lookup(q2_id, er, ev);
      chk("q2_ready", 32'(q2_ready), 32'(er));
      chk("q2_value", q2_value, ev);
      model_step();
      @(posedge clk_in);
      #1;
      chk("rob_full", 32'(rob_full), 32'(m_full));
      chk("tail_id", 32'(rob_tail_id), 32'(m_tail));
      chk("commit_valid", 32'(commit_valid), 32'(e_cv));
      if (e_cv) begin
        chk("commit_rd", 32'(commit_rd), 32'(e_rd));
        chk("commit_value", commit_value, e_val);
        chk("commit_id", 32'(commit_id), 32'(e_id));
      end
      chk("commit_store", 32'(commit_store), 32'(e_cs));
      if (e_cs) chk("commit_store_id", 32'(commit_store_id), 32'(e_sid));
      chk("rob_clear", 32'(rob_clear), 32'(m_clr));
      if (m_clr) chk("clear_pc", clear_pc, e_pc);
      if (cyc == 2000) begin
        rst_in = 1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        #1 rst_in = 0;
      end
    end
    chk("saw_commits", 32'(n_commit > 100), 1);
    chk("saw_clears", 32'(n_clear > 5), 1);
    chk("saw_stores", 32'(n_store > 5), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
